// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and its ALU.
// Holds ALU opcodes, FSM state encoding and the datapath width.
package mul_seq_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned CntWidth  = 5;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSub = 3'b100,
        AluSlt = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIter,
        StFixA,
        StFixB,
        StDone
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, subtract, and, or, set-less-than.
// carry_out is the adder carry on ADD and the borrow on SUB.
module alu
    import mul_seq_pkg::*;
(
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [2:0]           op,
    output logic [DataWidth-1:0] result,
    output logic                 carry_out
);

    logic [DataWidth:0] sum;
    logic [DataWidth:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        case (alu_op_e'(op))
            AluAdd: {carry_out, result} = sum;
            AluSub: {carry_out, result} = diff;
            AluAnd: result = a & b;
            AluOr:  result = a | b;
            AluSlt: result = {{(DataWidth-1){1'b0}}, $signed(a) < $signed(b)};
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 shift-add multiplier, signed or unsigned, 64-bit product.
// All arithmetic is issued to an external combinational ALU through the alu_* ports.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_a,
    input  logic [DataWidth-1:0] in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DataWidth-1:0] out_prod,
    output logic [DataWidth-1:0] alu_A,
    output logic [DataWidth-1:0] alu_B,
    output logic [2:0]           alu_ALUop,
    input  logic [DataWidth-1:0] alu_Result,
    input  logic                 alu_CarryOut
);

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [DataWidth-1:0]  hi_q;
    logic [DataWidth-1:0]  lo_q;
    logic [DataWidth-1:0]  a_q;
    logic [DataWidth-1:0]  b_q;
    logic                  sgn_q;
    alu_op_e               alu_op;

    assign out_prod  = {hi_q, lo_q};
    assign alu_ALUop = alu_op;

    always_comb begin
        alu_A  = '0;
        alu_B  = '0;
        alu_op = AluAdd;
        case (state_q)
            StIter: begin
                alu_A = hi_q;
                alu_B = lo_q[0] ? a_q : '0;
            end
            // Two's-complement correction: subtract the weight the unsigned
            // interpretation gave each operand's sign bit.
            StFixA: begin
                alu_A  = hi_q;
                alu_B  = a_q[DataWidth-1] ? b_q : '0;
                alu_op = AluSub;
            end
            StFixB: begin
                alu_A  = hi_q;
                alu_B  = b_q[DataWidth-1] ? a_q : '0;
                alu_op = AluSub;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        sgn_q    <= in_signed;
                        hi_q     <= '0;
                        lo_q     <= in_b;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StIter;
                    end
                end
                StIter: begin
                    // Partial sum shifts right one bit into lo as multiplier bits retire.
                    {hi_q, lo_q} <= {alu_CarryOut, alu_Result, lo_q[DataWidth-1:1]};
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CntWidth'(DataWidth - 1)) begin
                        if (sgn_q) begin
                            state_q <= StFixA;
                        end else begin
                            state_q   <= StDone;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StFixA: begin
                    hi_q    <= alu_Result;
                    state_q <= StFixB;
                end
                StFixB: begin
                    hi_q      <= alu_Result;
                    state_q   <= StDone;
                    out_valid <= 1'b1;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq driving the alu; compares against a
// 64-bit arithmetic model with handshake/latency tracking.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_ALUop;
    logic [31:0] alu_Result;
    logic        alu_CarryOut;

    int total = 0;
    int bad   = 0;

    mul_seq u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_signed    (in_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_prod     (out_prod),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_ALUop    (alu_ALUop),
        .alu_Result   (alu_Result),
        .alu_CarryOut (alu_CarryOut)
    );

    alu u_alu (
        .a         (alu_A),
        .b         (alu_B),
        .op        (alu_ALUop),
        .result    (alu_Result),
        .carry_out (alu_CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Transaction-level model: busy from accepted request until product taken,
    // product due a fixed number of cycles after the request.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_lat  = 0;
    logic [63:0] m_prod = '0;
    bit          m_ov;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            check64("rst_in_ready", 64'(in_ready), 64'd1);
            check64("rst_out_valid", 64'(out_valid), 64'd0);
            check64("rst_out_prod", out_prod, 64'd0);
        end else begin
            if (m_busy) m_age++;
            m_ov = m_busy && (m_age >= m_lat);
            check64("cyc_in_ready", 64'(in_ready), 64'(!m_busy));
            check64("cyc_out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov) check64("cyc_out_prod", out_prod, m_prod);
            if (!m_busy && in_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_lat  = in_signed ? 35 : 33;
                m_prod = model(in_a, in_b, in_signed);
            end else if (m_ov && out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Issues one request from IDLE, scrambles inputs while busy, stalls the
    // consumer for 'stall' cycles, then takes the product.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int stall, input logic [63:0] exp);
        int          lat;
        logic [63:0] res;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 60) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: no out_valid after %0d cycles, required %0d",
                     name, lat, s ? 35 : 33);
            finish_run();
        end
        check64({name, "_lat"}, 64'(lat), s ? 64'd35 : 64'd33);
        res = out_prod;
        check64(name, res, exp);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = $urandom;
            @(posedge clk); #1;
            check64({name, "_hold_v"}, 64'(out_valid), 64'd1);
            check64({name, "_hold_p"}, out_prod, res);
            check64({name, "_hold_rdy"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check64({name, "_idle_rdy"}, 64'(in_ready), 64'd1);
        check64({name, "_idle_v"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check64("model_u_max", model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        check64("model_s_m1x3", model(32'hFFFF_FFFF, 32'h3, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
        check64("model_s_min", model(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);
        check64("model_7x6", model(32'd7, 32'd6, 1'b0), 64'd42);

        run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001);
        run_op("s_m1x3", 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1, 64'h4000_0000_0000_0000);
        run_op("s_zero", 32'h0, 32'h8000_0001, 1'b1, 0, 64'd0);
        run_op("backpressure", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10,
               64'h0B00_EA4E_242D_2080);

        // Abandon an operation part-way through ITER.
        in_valid  = 1'b1;
        in_a      = 32'd123;
        in_b      = 32'd456;
        in_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check64("midrst_in_ready", 64'(in_ready), 64'd1);
        check64("midrst_out_valid", 64'(out_valid), 64'd0);
        check64("midrst_out_prod", out_prod, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("after_rst", 32'd7, 32'd6, 1'b0, 0, 64'd42);

        for (int n = 0; n < 1200; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rs, $urandom_range(0, 2), model(ra, rb, rs));
        end

        finish_run();
    end

endmodule
